delay_line_ctrl: RTL and testbench
==================================

// Module: delay_line_ctrl
// PURPOSE
//  Sequencer for the voice delay datapath (address counter + dual-port RAM).
//  On start it primes the RAM with `offset` address-units of samples (output muted),
//  then runs write/read in lockstep one sample per tick, and on stop drains the remaining delayed samples.
//  Sits between the sample-rate tick source and the RAM write/read ports.
// PARAMETERS
//  A_WIDTH  9  RAM address width; delay offset width
//  D_WIDTH  8  increment width (pointer step per tick)
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rst          in   1        synchronous, active-high reset
//  start        in   1        begin capture (sampled only in IDLE)
//  stop         in   1        end capture (sampled in PRIME/RUN)
//  sample_tick  in   1        one-cycle strobe, one sample per strobe
//  offset       in   A_WIDTH  delay in address units, latched on accepted start
//  incr         in   D_WIDTH  pointer step per tick, latched on accepted start
//  wr_en        out  1        RAM write strobe
//  rd_en        out  1        RAM read strobe
//  wr_addr      out  A_WIDTH  RAM write address
//  rd_addr      out  A_WIDTH  RAM read address
//  out_valid    out  1        RAM dout carries a delayed sample this cycle
//  state        out  2        IDLE=0 PRIME=1 RUN=2 DRAIN=3
//  cfg_err      out  1        one-cycle pulse: start rejected
// BEHAVIOUR
//  - Reset: state=IDLE; wr_en=rd_en=out_valid=cfg_err=0; wr_addr=rd_addr=0; wr_ptr=0; tick counter=0.
//    Reset at any point aborts the current operation; there is no partial drain.
//  - All outputs registered. Tick on cycle N -> wr_en/rd_en and addresses valid on N+1, one cycle wide.
//  - out_valid = rd_en delayed 1 cycle (RAM read latency 1).
//  - Accepted start:
//    - Requires offset!=0 and incr!=0; otherwise stay IDLE and pulse cfg_err on the next cycle.
//    - On acceptance: latch offset and incr, wr_ptr=0, acc=0, ticks=0, go to PRIME.
//  - PRIME: each tick writes at wr_ptr, then wr_ptr+=incr (mod 2^A_WIDTH) and ticks+=1.
//    - acc+=incr in an A_WIDTH+1-bit accumulator saturating at all-ones.
//    - When acc>=offset after the update, go to RUN; the next tick is the first RUN tick.
//    - rd_en=0 throughout PRIME.
//  - RUN: each tick writes at wr_ptr and reads rd_addr=(wr_ptr-offset) mod 2^A_WIDTH, then wr_ptr+=incr.
//    - Write and read are issued in the same cycle; the RAM's port 2 returns old data, with no bypass.
//  - DRAIN: each tick issues only a read at (wr_ptr-offset) (wr_en=0), then wr_ptr+=incr and ticks-=1.
//    - Go to IDLE when ticks reaches 0.
//  - stop in PRIME: go straight to IDLE (no valid output was produced).
//  - stop in RUN: enter DRAIN. ticks holds the PRIME tick count, so DRAIN emits exactly that many reads.
//  - stop and sample_tick in the same cycle: the tick is processed in the current state first, then the transition.
//  - start outside IDLE and stop in IDLE/DRAIN are ignored.
//  - offset/incr input changes after acceptance have no effect until the next start.
//  - Pointer wrap: modulo 2^A_WIDTH, with no flag.
//  - offset larger than the capacity reachable by incr still works through the saturating acc.
// TESTING
//  - Reset: assert rst mid-RUN -> next cycle state=0, all strobes 0, wr_addr=rd_addr=0.
//  - Prime/run with offset=4, incr=1, ticks every 3 cycles:
//    - 4 writes at addr 0..3 with rd_en=0.
//    - 5th tick: wr_addr=4, rd_addr=0, out_valid one cycle after rd_en.
//  - Wrap with A_WIDTH=9, offset=2, incr=1: tick at wr_ptr=511 -> wr_addr=511, rd_addr=509;
//    the next tick gives wr_addr=0, rd_addr=510.
//  - Drain: offset=3, incr=1, stop after 10 RUN ticks -> exactly 3 read-only ticks, then state=0.
//  - Config error: start with offset=0 -> cfg_err pulses once, state stays 0, no strobes.
//  - Same-cycle events: stop together with a tick in RUN -> that tick writes and reads, then state=3.
//    start during RUN -> ignored.

Source files
------------

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: sequencer that primes, runs and drains a RAM-based sample delay line.
// Ports: clk/rst (sync, active-high); start/stop/sample_tick control; offset/incr config
// latched on accepted start; wr_en/rd_en/wr_addr/rd_addr drive the RAM; out_valid marks
// RAM dout carrying a delayed sample; state IDLE=0 PRIME=1 RUN=2 DRAIN=3; cfg_err start-rejected pulse.
module delay_line_ctrl #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               sample_tick,
  input  logic [A_WIDTH-1:0] offset,
  input  logic [D_WIDTH-1:0] incr,
  output logic               wr_en,
  output logic               rd_en,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic [A_WIDTH-1:0] rd_addr,
  output logic               out_valid,
  output logic [1:0]         state,
  output logic               cfg_err
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d, offset_q, offset_d;
  logic [A_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [D_WIDTH-1:0] incr_q, incr_d;
  logic [A_WIDTH:0]   acc_q, acc_d, ticks_q, ticks_d;
  logic               wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic               out_valid_q, out_valid_d, cfg_err_q, cfg_err_d;
  logic [A_WIDTH+1:0] acc_sum;
  logic [A_WIDTH-1:0] ptr_next, rd_ptr;
  always_comb begin
    acc_sum     = {1'b0, acc_q} + (A_WIDTH+2)'(incr_q);
    ptr_next    = wr_ptr_q + A_WIDTH'(incr_q);
    rd_ptr      = wr_ptr_q - offset_q;
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    offset_d    = offset_q;
    incr_d      = incr_q;
    acc_d       = acc_q;
    ticks_d     = ticks_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    cfg_err_d   = 1'b0;
    out_valid_d = rd_en_q;
    case (state_q)
      IDLE: begin
        if (start && offset != '0 && incr != '0) begin
          offset_d = offset;
          incr_d   = incr;
          wr_ptr_d = '0;
          acc_d    = '0;
          ticks_d  = '0;
          state_d  = PRIME;
        end else if (start) begin
          cfg_err_d = 1'b1;
        end
      end
      PRIME: begin
        if (sample_tick) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_ptr_q;
          wr_ptr_d  = ptr_next;
          ticks_d   = ticks_q + 1'b1;
          // saturating add keeps huge offsets reachable instead of wrapping
          acc_d     = acc_sum[A_WIDTH+1] ? '1 : acc_sum[A_WIDTH:0];
        end
        state_d = stop ? IDLE : (sample_tick && acc_d >= {1'b0, offset_q}) ? RUN : PRIME;
      end
      RUN: begin
        if (sample_tick) begin
          wr_en_d   = 1'b1;
          rd_en_d   = 1'b1;
          wr_addr_d = wr_ptr_q;
          rd_addr_d = rd_ptr;
          wr_ptr_d  = ptr_next;
        end
        state_d = stop ? DRAIN : RUN;
      end
      default: begin
        if (sample_tick) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_ptr;
          wr_ptr_d  = ptr_next;
          ticks_d   = ticks_q - 1'b1;
        end
        state_d = (ticks_d == '0) ? IDLE : DRAIN;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      offset_q    <= '0;
      incr_q      <= '0;
      acc_q       <= '0;
      ticks_q     <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      offset_q    <= offset_d;
      incr_q      <= incr_d;
      acc_q       <= acc_d;
      ticks_q     <= ticks_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end
  assign state     = state_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign wr_addr   = wr_addr_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl: directed plus random stimulus against a behavioural delay-line model.
module tb_delay_line_ctrl;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int SZ = 1 << AW;
  logic clk = 0, rst, start, stop, sample_tick;
  logic [AW-1:0] offset, wr_addr, rd_addr;
  logic [DW-1:0] incr;
  logic wr_en, rd_en, out_valid, cfg_err;
  logic [1:0] state;
  int n_chk = 0, n_pass = 0, ro_cnt = 0;
  int m_st, m_ptr, m_acc, m_tk, m_off, m_inc;
  int e_wr, e_rd, e_ov, e_err, e_wa, e_ra;
  bit e_rst;
  delay_line_ctrl #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_tick(sample_tick),
    .offset(offset), .incr(incr), .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr),
    .rd_addr(rd_addr), .out_valid(out_valid), .state(state), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  // Reference: delay line described as a pointer walking the RAM, reading `offset` behind the writer.
  task automatic model(input bit r, input bit st, input bit sp, input bit tk, input int off, input int inc);
    e_ov = e_rd;
    e_wr = 0;
    e_rd = 0;
    e_err = 0;
    e_rst = r;
    if (r) begin
      m_st = 0; m_ptr = 0; m_acc = 0; m_tk = 0; e_wa = 0; e_ra = 0; e_ov = 0;
      return;
    end
    case (m_st)
      0: if (st) begin
        if (off != 0 && inc != 0) begin
          m_off = off; m_inc = inc; m_ptr = 0; m_acc = 0; m_tk = 0; m_st = 1;
        end else e_err = 1;
      end
      1: begin
        if (tk) begin
          e_wr = 1; e_wa = m_ptr;
          m_ptr = (m_ptr + m_inc) % SZ;
          m_tk++;
          m_acc = (m_acc + m_inc > 2 * SZ - 1) ? 2 * SZ - 1 : m_acc + m_inc;
        end
        if (sp) m_st = 0;
        else if (tk && m_acc >= m_off) m_st = 2;
      end
      2: begin
        if (tk) begin
          e_wr = 1; e_rd = 1; e_wa = m_ptr; e_ra = (m_ptr - m_off + SZ) % SZ;
          m_ptr = (m_ptr + m_inc) % SZ;
        end
        if (sp) m_st = 3;
      end
      default: begin
        if (tk) begin
          e_rd = 1; e_ra = (m_ptr - m_off + SZ) % SZ;
          m_ptr = (m_ptr + m_inc) % SZ;
          m_tk--;
        end
        if (m_tk == 0) m_st = 0;
      end
    endcase
  endtask
  task automatic cyc(input bit r, input bit st, input bit sp, input bit tk, input int off, input int inc);
    rst = r; start = st; stop = sp; sample_tick = tk;
    offset = off[AW-1:0]; incr = inc[DW-1:0];
    model(r, st, sp, tk, off, inc);
    @(posedge clk);
    @(negedge clk);
    chk("state", state, m_st);
    chk("wr_en", wr_en, e_wr);
    chk("rd_en", rd_en, e_rd);
    chk("out_valid", out_valid, e_ov);
    chk("cfg_err", cfg_err, e_err);
    if (e_wr || e_rst) chk("wr_addr", wr_addr, e_wa);
    if (e_rd || e_rst) chk("rd_addr", rd_addr, e_ra);
    if (rd_en && !wr_en) ro_cnt++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, $urandom_range(0, SZ - 1), $urandom_range(0, 255));
  endtask
  initial begin
    e_rd = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 4, 1);
    idle(2);
    // prime/run, offset 4 incr 1, ticks every 3 cycles
    cyc(0, 1, 0, 0, 4, 1);
    for (int t = 1; t <= 7; t++) begin
      cyc(0, 0, 0, 1, 4, 1);
      if (t <= 4) begin
        chk("prime_wa", wr_addr, t - 1);
        chk("prime_rd", rd_en, 0);
      end
      if (t == 5) begin
        chk("run5_wa", wr_addr, 4);
        chk("run5_ra", rd_addr, 0);
      end
      cyc(0, 0, 0, 0, 7, 9);
      if (t == 5) chk("run5_ov", out_valid, 1);
      cyc(0, t == 6, 0, 0, 0, 0);
    end
    chk("run_state", state, 2);
    cyc(1, 0, 0, 1, 4, 1);
    chk("rst_state", state, 0);
    chk("rst_wa", wr_addr, 0);
    chk("rst_ra", rd_addr, 0);
    // config error
    cyc(0, 1, 0, 0, 0, 3);
    chk("cfg_err_pulse", cfg_err, 1);
    idle(1);
    chk("cfg_err_once", cfg_err, 0);
    cyc(0, 1, 0, 0, 5, 0);
    idle(2);
    // drain: offset 3 incr 1, 10 RUN ticks, stop on the last tick, start during RUN ignored
    cyc(0, 1, 0, 0, 3, 1);
    for (int t = 0; t < 13; t++) begin
      cyc(0, t == 6, t == 12, 1, 3, 1);
      if (t == 12) begin
        chk("stop_tick_wr", wr_en, 1);
        chk("stop_tick_rd", rd_en, 1);
        chk("stop_state", state, 3);
      end
    end
    ro_cnt = 0;
    for (int t = 0; t < 12 && state != 0; t++) cyc(0, 0, t == 1, t % 2 == 0, 3, 1);
    chk("drain_reads", ro_cnt, 3);
    chk("drain_idle", state, 0);
    // wrap: offset 2 incr 1, every cycle a tick
    cyc(0, 1, 0, 0, 2, 1);
    for (int t = 1; t <= 513; t++) begin
      cyc(0, 0, 0, 1, 2, 1);
      if (t == 512) begin
        chk("wrap_wa", wr_addr, 511);
        chk("wrap_ra", rd_addr, 509);
      end
      if (t == 513) begin
        chk("wrap_wa2", wr_addr, 0);
        chk("wrap_ra2", rd_addr, 510);
      end
    end
    cyc(0, 0, 1, 0, 0, 0);
    for (int t = 0; t < 10 && state != 0; t++) cyc(0, 0, 0, 1, 0, 0);
    chk("wrap_drained", state, 0);
    // random
    for (int i = 0; i < 6000; i++) begin
      int off, inc;
      off = ($urandom_range(0, 9) == 0) ? 0 : ($urandom_range(0, 4) == 0) ? $urandom_range(1, SZ - 1) : $urandom_range(1, 40);
      inc = ($urandom_range(0, 9) == 0) ? 0 : ($urandom_range(0, 2) == 0) ? $urandom_range(1, 255) : $urandom_range(1, 4);
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, 2) == 0, off, inc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
